pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the NPC pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a packed payload with a valid/ready handshake and supports flush.
- In skid mode it registers `in_ready` with a 2-entry skid buffer, sustaining 1 transfer/cycle without a combinational ready path.
- Replaces hand-written per-stage registers that only support enable plus bubble-reset.

Parameters:
- W, 64, payload width in bits (>=1).
- SKID, 1, 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with `in_ready = out_ready | ~out_valid`.
- RESET_VAL, {W{1'b0}}, payload value loaded on reset/flush (bubble value, e.g. PC 0x80000000 in low bits).
- CNT_W, 32, width of optional statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  drop all held entries at next edge.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; transfer when `in_valid & in_ready`.
- in_data  in  W  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts; transfer when `out_valid & out_ready`.
- out_data  out  W  payload to next stage (always the main register).
- stall_cnt  out  CNT_W  cycles with `out_valid & ~out_ready` (macro only, else 0).
- flush_cnt  out  CNT_W  valid entries discarded by flush (macro only, else 0).

Behaviour:
- Reset (async assert, sync release):
  - `out_valid = 0`, `out_data = RESET_VAL`.
  - skid register = RESET_VAL, state EMPTY.
  - `in_ready = 1`; counters = 0.
- Latency: 1 cycle from input fire to `out_valid` when empty. Throughput: 1/cycle in both modes.
- SKID=1 states, with `in_ready = (state != FULL)`, registered:
  - EMPTY:
    - in fire -> BUSY, main <= in_data.
  - BUSY:
    - in fire & out fire -> BUSY, main <= in_data.
    - in fire & ~out_ready -> FULL, skid <= in_data.
    - no in fire & out fire -> EMPTY.
    - else hold.
  - FULL:
    - out fire -> BUSY, main <= skid.
    - else hold. No input is accepted.
- SKID=0: single register.
  - `in_ready` is combinational: `out_ready | ~out_valid`.
  - Load on in fire; clear valid on out fire without in fire.
- Flush (both modes):
  - Next state EMPTY; `out_valid` 0 next cycle; main and skid <= RESET_VAL.
  - An input fire in the same cycle is discarded.
  - An output fire in the same cycle still counts as delivered; downstream sees it.
  - Flush has priority over all handshake transitions.
- Ordering: strict FIFO. The skid entry is always older than any later input.
- `out_data` is stable while `out_valid & ~out_ready`; no input change may alter it.
- `in_data` is ignored when `~in_valid`; main is not written.
- Reset asserted mid-transfer: all state is lost immediately. No partial payload is ever presented with `out_valid = 1`.

Optional Feature:
- Macro PIPE_STAGE_REG_STATS_EN.
- Defined:
  - `stall_cnt` increments each cycle with `out_valid & ~out_ready & ~flush`.
  - `flush_cnt` adds the number of valid held entries (0/1/2) on each flush cycle.
  - Both saturate at all-ones.
- Undefined: both outputs are constant 0 and no counter flops are synthesised.

Decomposition:
- Shared package `pipe_pkg`:
  - State enum (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2).
  - Default reset-PC constant 64'h8000_0000.
  - Per-stage packed payload struct typedefs (EX/MEM etc.) so that W = $bits(struct).
- Optional sub-module `sat_counter` (CNT_W, inc amount) instantiated twice under the macro. The core needs no further split.

Test Plan:
- Reset: assert rst mid-cycle with state FULL -> immediately `out_valid = 0`, `out_data = RESET_VAL`, `in_ready = 1`; after release, one in fire of 0xA -> `out_valid = 1`, `out_data = 0xA` next cycle.
- Streaming (SKID=1 and SKID=0): `out_ready` held 1, inputs 1..100 back-to-back -> outputs 1..100 in order, one per cycle, first at cycle+1.
- Backpressure (SKID=1): inputs 0x11, 0x22, 0x33 with `out_ready = 0` -> state FULL, `in_ready = 0`, 0x33 not accepted. Raise `out_ready` -> outputs 0x11, 0x22, then 0x33 after re-accept; no loss or duplication.
- Flush: state FULL (0x11, 0x22), flush with `in_valid = 1`, `in_data = 0x99` -> next cycle `out_valid = 0`, `out_data = RESET_VAL`, 0x99 dropped, `flush_cnt = 2` (macro on).
- Simultaneous in/out fire in BUSY with `out_ready = 1`, then `out_ready = 0` for 3 cycles -> `stall_cnt = 3` (macro on; 0 with macro off); `out_data` stable.
- Random valid/ready/flush against a reference queue model, 10k cycles, both SKID values -> scoreboard match and no combinational ready path when SKID=1 (lint check).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the NPC inter-stage pipeline registers.
//   stage_state_e : occupancy state of a skid-mode stage register
//   ResetPc       : default bubble PC for payloads that carry a PC
//   *_t           : per-stage payload structs; instantiate with W = $bits(<struct>)
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

  localparam logic [63:0] ResetPc = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } id_ex_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] alu_res;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } ex_mem_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline-stage statistics.
//   clk, rst : clock, asynchronous active-high reset (count returns to 0)
//   inc      : amount (0..3) added this cycle
//   cnt      : current count, sticks at all-ones once reached
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  // One spare bit catches the carry that signals saturation.
  assign sum = {1'b0, cnt_q} + {{(CNT_W - 1){1'b0}}, inc};

  always_comb begin
    cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake and flush.
// SKID=1: 2-entry skid buffer, in_ready comes straight from a state flop.
// SKID=0: single register, in_ready = out_ready | ~out_valid (combinational).
// Optional statistics counters enabled by defining PIPE_STAGE_REG_STATS_EN.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : drop all held entries at the next edge
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data = main register
//   stall_cnt           : cycles with out_valid & ~out_ready & ~flush
//   flush_cnt           : valid entries discarded by flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned  W         = 64,
  parameter bit           SKID      = 1'b1,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter int unsigned  CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [W-1:0] main_q;

  if (SKID != 1'b0) begin : g_skid
    stage_state_e state_q, state_d;
    logic [W-1:0] main_d, skid_q, skid_d;
    logic         in_fire;

    assign in_fire = in_valid & in_ready;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = StEmpty;
        main_d  = RESET_VAL;
        skid_d  = RESET_VAL;
      end else begin
        case (state_q)
          StEmpty: begin
            if (in_fire) begin
              state_d = StBusy;
              main_d  = in_data;
            end
          end
          StBusy: begin
            // out_valid is 1 here, so out_ready alone means output fire.
            if (in_fire && out_ready) begin
              main_d = in_data;
            end else if (in_fire) begin
              state_d = StFull;
              skid_d  = in_data;
            end else if (out_ready) begin
              state_d = StEmpty;
            end
          end
          StFull: begin
            if (out_ready) begin
              state_d = StBusy;
              main_d  = skid_q;
            end
          end
          default: state_d = StEmpty;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= StEmpty;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
  end else begin : g_reg
    logic valid_q;
    logic in_fire;

    assign in_fire = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else if (flush) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else if (in_fire) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign in_ready  = out_ready | ~valid_q;
    assign out_valid = valid_q;
  end

  assign out_data = main_q;

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [1:0] held_cnt;
  logic [1:0] flush_inc;
  logic [1:0] stall_inc;

  // Skid mode: ~in_ready marks FULL (two entries), otherwise out_valid marks one.
  assign held_cnt  = (SKID != 1'b0) ? {~in_ready, out_valid & in_ready} : {1'b0, out_valid};
  assign flush_inc = flush ? held_cnt : 2'd0;
  assign stall_inc = {1'b0, out_valid & ~out_ready & ~flush};

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall_inc),
    .cnt(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(flush_inc),
    .cnt(flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
